// File: rtl/cmp_zelg_seq_if.sv
// Handshake and operand/result bundle for the chunked sequential comparator.
// The master side issues compare requests; the slave side is the comparator.
interface cmp_zelg_seq_if #(
  parameter int p_WIDTH = 8
);
  logic               i_start;
  logic               i_signed;
  logic [p_WIDTH-1:0] iv_x;
  logic [p_WIDTH-1:0] iv_y;
  logic               o_busy;
  logic               o_done;
  logic               o_zero;
  logic               o_equal;
  logic               o_less;
  logic               o_greater;

  modport master (
    output i_start, i_signed, iv_x, iv_y,
    input  o_busy, o_done, o_zero, o_equal, o_less, o_greater
  );

  modport slave (
    input  i_start, i_signed, iv_x, iv_y,
    output o_busy, o_done, o_zero, o_equal, o_less, o_greater
  );
endinterface

// File: rtl/cmp_zelg_seq.sv
// Sequential zero/equal/less/greater comparator.
// Walks the operands p_CHUNK bits per clock from the MSB chunk downwards and
// stops at the first chunk that differs. Signed mode flips the sign bit of
// both operands so that a plain unsigned chunk compare gives the signed order.
module cmp_zelg_seq #(
  parameter int p_WIDTH = 8,
  parameter int p_CHUNK = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  cmp_zelg_seq_if.slave  bus
);

  localparam int N     = p_WIDTH / p_CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
  localparam logic [p_WIDTH-1:0] SIGN_MASK = p_WIDTH'(1) << (p_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [p_WIDTH-1:0] x_raw;
  logic [p_WIDTH-1:0] y_raw;
  logic [p_WIDTH-1:0] x_adj;
  logic [p_WIDTH-1:0] y_adj;
  logic               mode;
  logic [IDX_W-1:0]   idx;
  logic               any_set;

  logic [p_CHUNK-1:0] x_chunk;
  logic [p_CHUNK-1:0] y_chunk;
  logic [p_CHUNK-1:0] x_chunk_raw;

  logic zero;
  logic equal;
  logic less;
  logic greater;
  logic zero_next;
  logic equal_next;
  logic less_next;
  logic greater_next;

  logic load;
  logic step;
  logic finish;

  // Sign-bit inversion maps two's-complement order onto unsigned order.
  assign x_adj = mode ? (x_raw ^ SIGN_MASK) : x_raw;
  assign y_adj = mode ? (y_raw ^ SIGN_MASK) : y_raw;

  // Current chunk is selected by shifting, so the index width never matters.
  assign x_chunk     = p_CHUNK'(x_adj >> (int'(idx) * p_CHUNK));
  assign y_chunk     = p_CHUNK'(y_adj >> (int'(idx) * p_CHUNK));
  assign x_chunk_raw = p_CHUNK'(x_raw >> (int'(idx) * p_CHUNK));

  assign bus.o_busy    = (state == RUN);
  assign bus.o_done    = (state == DONE);
  assign bus.o_zero    = zero;
  assign bus.o_equal   = equal;
  assign bus.o_less    = less;
  assign bus.o_greater = greater;

  // State register; reset aborts any compare in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the flag values to capture when a compare resolves.
  always_comb begin
    state_next   = state;
    load         = 1'b0;
    step         = 1'b0;
    finish       = 1'b0;
    zero_next    = zero;
    equal_next   = equal;
    less_next    = less;
    greater_next = greater;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (x_chunk != y_chunk) begin
          finish       = 1'b1;
          state_next   = DONE;
          less_next    = (x_chunk < y_chunk);
          greater_next = (x_chunk > y_chunk);
          equal_next   = 1'b0;
          zero_next    = 1'b0;
        end else if (idx == '0) begin
          finish       = 1'b1;
          state_next   = DONE;
          equal_next   = 1'b1;
          less_next    = 1'b0;
          greater_next = 1'b0;
          zero_next    = ~(any_set | (|x_chunk_raw));
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on start, then chunk index walk and raw-X OR accumulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_raw   <= '0;
      y_raw   <= '0;
      mode    <= 1'b0;
      idx     <= '0;
      any_set <= 1'b0;
    end else if (load) begin
      x_raw   <= bus.iv_x;
      y_raw   <= bus.iv_y;
      mode    <= bus.i_signed;
      idx     <= LAST_IDX;
      any_set <= 1'b0;
    end else if (step) begin
      idx     <= idx - 1'b1;
      any_set <= any_set | (|x_chunk_raw);
    end
  end

  // Result flags change only when a compare resolves and then hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      zero    <= 1'b0;
      equal   <= 1'b0;
      less    <= 1'b0;
      greater <= 1'b0;
    end else if (finish) begin
      zero    <= zero_next;
      equal   <= equal_next;
      less    <= less_next;
      greater <= greater_next;
    end
  end

endmodule

// File: doc/cmp_zelg_seq.md
Name: cmp_zelg_seq

Overview:
- Sequential, parametrised successor to the combinational zero/equal/less/greater comparator.
- Compares two p_WIDTH-bit operands p_CHUNK bits per clock, MSB chunk first.
- Terminates early on the first differing chunk.
- Supports unsigned and two's-complement signed modes, with a start/done handshake.
- Serves wide-operand compare paths where a full-width combinational compare would break timing.

Parameters:
- p_WIDTH, 8, operand width in bits (>=1).
- p_CHUNK, 2, bits compared per cycle. Must divide p_WIDTH (1 <= p_CHUNK <= p_WIDTH). N = p_WIDTH/p_CHUNK.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  request a comparison; sampled only in IDLE.
- i_signed  in  1  1 = two's-complement compare, 0 = unsigned; latched with operands.
- iv_x  in  p_WIDTH  operand X.
- iv_y  in  p_WIDTH  operand Y.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse: result valid.
- o_zero  out  1  X==0 and Y==0.
- o_equal  out  1  X==Y.
- o_less  out  1  X<Y in the selected mode.
- o_greater  out  1  X>Y in the selected mode.

Behaviour:
- Reset (async, any state): state=IDLE; o_busy, o_done, o_zero, o_equal, o_less, o_greater all 0; chunk index 0. Reset mid-RUN aborts with no o_done.
- States: IDLE, RUN, DONE.
- IDLE:
  - On edge with i_start=1: latch iv_x, iv_y, i_signed; chunk index=N-1 (MSB chunk); go RUN.
  - Flags keep their previous result; they are not cleared on start.
- Signed mode: invert bit p_WIDTH-1 of both latched operands, then compare unsigned. Unsigned mode: no inversion.
- RUN, each edge, compare current chunk of X vs Y:
  - Chunks differ: set o_less/o_greater per the chunk compare; o_equal=0, o_zero=0; go DONE.
  - Chunks equal and index==0: o_equal=1, less=greater=0, o_zero=1 iff all latched raw X bits are 0 (accumulated OR, pre-inversion); go DONE.
  - Otherwise: index-1; stay RUN.
- DONE: o_done=1 for exactly one cycle; flags valid; next edge -> IDLE. o_busy=0.
- Latency, start edge to edge entering DONE:
  - k+1 edges when the first differing chunk is the k-th from the MSB, 0-based.
  - N edges when the operands are equal.
  - o_done is high the cycle after that edge.
- Flags update only on the edge entering DONE. They hold until the next result or reset. Exactly one of equal/less/greater is 1 after any completed compare.
- i_start in RUN or DONE is ignored; no queueing.
- Operand/mode changes after the start edge have no effect on the running compare.
- p_CHUNK==p_WIDTH: single-cycle RUN, identical truth table to the combinational comparator.

Test Plan:
- p_WIDTH=8, p_CHUNK=2, unsigned, X=0x00, Y=0x00 -> o_done 4 edges after start; Z=1 E=1 L=0 G=0; o_busy high 4 cycles.
- X=0xC0, Y=0x3F: unsigned -> done after 1 edge, G=1 L=0 E=0 Z=0. Same operands, signed -> done after 1 edge, L=1 G=0.
- X=0x12, Y=0x13, unsigned -> done after 4 edges, L=1; X=0x05, Y=0x00 -> G=1, Z=0.
- Start X=0x12, Y=0x13; pulse i_start with X=0xFF and change iv_x during RUN -> ignored, result L=1. Separately, assert i_rst at cycle 2 of RUN -> all outputs 0 immediately, no o_done, next start works normally.
- Exhaustive sweep against a behavioural model: p_WIDTH 1..4, p_CHUNK in {1, p_WIDTH}, both modes, all X,Y pairs -> flags match the model, o_done once per start, latency matches the rule above.
